// File: rtl/stream_fork_buf.sv
// stream_fork_buf: registered eager fork that broadcasts one ready/valid stream to NUM_OUTPUTS consumers.
// Define STREAM_FORK_BUF_STALL_CNT_EN to add the per-output saturating stall counters (stall_clr, stall_cnt).
module stream_fork_buf #(
   parameter int NUM_OUTPUTS = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int DATA2_WIDTH = 13,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [DATA_WIDTH-1:0]                in_data,
   input  logic signed [DATA2_WIDTH-1:0]        in_data2,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [NUM_OUTPUTS-1:0]               in_dest,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0]    out_data,
   output logic [NUM_OUTPUTS*DATA2_WIDTH-1:0]   out_data2,
   output logic [NUM_OUTPUTS-1:0]               out_valid,
   input  logic [NUM_OUTPUTS-1:0]               out_ready
`ifdef STREAM_FORK_BUF_STALL_CNT_EN
   ,
   input  logic                                 stall_clr,
   output logic [NUM_OUTPUTS*CNT_WIDTH-1:0]     stall_cnt
`endif
);

   logic [NUM_OUTPUTS-1:0] pend;
   logic [DATA_WIDTH-1:0]  pl_data;
   logic [DATA2_WIDTH-1:0] pl_data2;
   logic                   accept;

   // NOTE: in_ready is gated by rst_n so no item can be taken while reset is held,
   // and it looks at this cycle's out_ready so the last transfer and a new accept overlap.
   assign in_ready = rst_n & ~|(pend & ~out_ready);
   assign accept   = in_valid & in_ready;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= '0;
         pl_data  <= '0;
         pl_data2 <= '0;
      end else if (accept) begin
         pend     <= in_dest;
         pl_data  <= in_data;
         pl_data2 <= in_data2;
      end else begin
         pend <= pend & ~out_ready;
      end
   end

   // Every slice carries the held payload; data2 bits pass through unextended.
   assign out_valid = pend;
   assign out_data  = {NUM_OUTPUTS{pl_data}};
   assign out_data2 = {NUM_OUTPUTS{pl_data2}};

`ifdef STREAM_FORK_BUF_STALL_CNT_EN
   for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_stall
      logic [CNT_WIDTH-1:0] cnt;

      // Clear wins over increment; the count sticks at all-ones instead of wrapping.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (stall_clr) begin
            cnt <= '0;
         end else if (pend[i] && !out_ready[i] && !(&cnt)) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
   end
`else
   // CNT_WIDTH only sizes the optional counters; tie it off so it is referenced.
   logic unused_cnt_width;
   assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_stream_fork_buf.sv
// Self-checking bench for stream_fork_buf: per-output scoreboard queues fed on accept, drained by a monitor.
// Directed cases from the block's behaviour plus a randomized phase; stall counter case when the macro is set.
module tb_stream_fork_buf;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int D2W = 13;
`ifdef STREAM_FORK_BUF_STALL_CNT_EN
   localparam int CW  = 4;
`else
   localparam int CW  = 16;
`endif

   typedef struct packed {
      logic [DW-1:0]  d;
      logic [D2W-1:0] d2;
   } item_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b1;
   logic [DW-1:0]        in_data = '0;
   logic signed [D2W-1:0] in_data2 = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [N-1:0]         in_dest = '0;
   logic [N*DW-1:0]      out_data;
   logic [N*D2W-1:0]     out_data2;
   logic [N-1:0]         out_valid;
   logic [N-1:0]         out_ready = '0;
`ifdef STREAM_FORK_BUF_STALL_CNT_EN
   logic                 stall_clr = 1'b0;
   logic [N*CW-1:0]      stall_cnt;
`endif

   item_t sb [N][$];
   item_t exp_pl = '0;
   item_t mon_item;
   logic  mon_rdy;
   int    n_vec = 0;
   int    n_err = 0;
   int    n_acc = 0;
   int    acc_mark;
   int    pending_total;

   stream_fork_buf #(
      .NUM_OUTPUTS(N),
      .DATA_WIDTH (DW),
      .DATA2_WIDTH(D2W),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_data2 (in_data2),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_dest  (in_dest),
      .out_data (out_data),
      .out_data2(out_data2),
      .out_valid(out_valid),
      .out_ready(out_ready)
`ifdef STREAM_FORK_BUF_STALL_CNT_EN
      ,
      .stall_clr(stall_clr),
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, idx, $time, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d, input logic [D2W-1:0] d2,
                       input logic [N-1:0] dest, input logic [N-1:0] rdy);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      in_data2  = d2;
      in_dest   = dest;
      out_ready = rdy;
   endtask

   // Monitor: model says an output is valid while its queue holds an item; input is
   // ready once every queued item is either gone or leaving this cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_out_valid", 0, 32'(out_valid), 32'd0);
         check("rst_in_ready", 0, 32'(in_ready), 32'd0);
         check("rst_out_data", 0, 32'(out_data[DW-1:0]), 32'd0);
      end else begin
         mon_rdy = 1'b1;
         for (int i = 0; i < N; i++)
            if (sb[i].size() > 1 || (sb[i].size() == 1 && !out_ready[i])) mon_rdy = 1'b0;
         check("in_ready", 0, 32'(in_ready), 32'(mon_rdy));
         for (int i = 0; i < N; i++) begin
            check("out_valid", i, 32'(out_valid[i]), 32'(sb[i].size() != 0));
            check("out_data", i, 32'(out_data[i*DW +: DW]), 32'(exp_pl.d));
            check("out_data2", i, 32'(out_data2[i*D2W +: D2W]), 32'(exp_pl.d2));
            if (out_valid[i] && out_ready[i] && sb[i].size() != 0) begin
               mon_item = sb[i].pop_front();
               check("xfer_item", i, 32'({out_data[i*DW +: DW], out_data2[i*D2W +: D2W]}), 32'(mon_item));
            end
         end
      end
   end

   // Stimulus side of the scoreboard: every accepted item is queued for its destinations.
   always @(negedge clk) begin
      #1;
      if (rst_n && in_valid && in_ready) begin
         exp_pl = {in_data, in_data2};
         n_acc++;
         for (int i = 0; i < N; i++)
            if (in_dest[i]) sb[i].push_back(exp_pl);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Single broadcast item.
      step(1'b1, 16'h1234, D2W'(-5), 4'b1111, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);

      // Staggered consumers.
      step(1'b1, 16'hBEEF, 13'h0123, 4'b1111, 4'b0000);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b0001);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b0011);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b0111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);

      // Back-to-back stream of 8 items.
      acc_mark = n_acc;
      for (int k = 0; k < 8; k++) step(1'b1, DW'(k), D2W'(k), 4'b1111, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      @(negedge clk);
      #2;
      check("b2b_accepts", 0, 32'(n_acc - acc_mark), 32'd8);

      // Destination mask selection, including an all-zero mask.
      step(1'b1, 16'h00A1, 13'h0A1, 4'b0101, 4'b1111);
      step(1'b1, 16'h00B2, 13'h0B2, 4'b0000, 4'b1111);
      step(1'b1, 16'h00C3, 13'h0C3, 4'b0010, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);

      // Reset while an item is outstanding on outputs 1 and 3.
      step(1'b1, 16'h5A5A, 13'h0AAA, 4'b1010, 4'b0000);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b0000);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) sb[i].delete();
      exp_pl = '0;
      #1;
      check("async_out_valid", 0, 32'(out_valid), 32'd0);
      check("async_in_ready", 0, 32'(in_ready), 32'd0);
      check("async_out_data", 0, 32'(out_data[DW-1:0]), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("post_rst_in_ready", 0, 32'(in_ready), 32'd1);
      repeat (3) step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);

      // Randomized traffic with random back-pressure.
      for (int c = 0; c < 1500; c++) begin
         logic [N-1:0] rdy;
         for (int i = 0; i < N; i++) rdy[i] = ($urandom_range(0, 3) != 0);
         step(($urandom_range(0, 3) != 0), DW'($urandom), D2W'($urandom), N'($urandom), rdy);
      end

      // Drain, bounded by a cycle budget.
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      for (int c = 0; c < 20; c++) begin
         pending_total = 0;
         for (int i = 0; i < N; i++) pending_total += sb[i].size();
         if (pending_total == 0) break;
         @(posedge clk);
      end
      check("drain_empty", 0, 32'(pending_total), 32'd0);

`ifdef STREAM_FORK_BUF_STALL_CNT_EN
      // Stall counters: output 2 held back for 20 cycles on a pending item.
      @(posedge clk);
      #1 stall_clr = 1'b1;
      @(posedge clk);
      #1 stall_clr = 1'b0;
      step(1'b1, 16'h7777, 13'h0777, 4'b0100, 4'b1011);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1011);
      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         check("stall_cnt", i, 32'(stall_cnt[i*CW +: CW]), (i == 2) ? 32'((1 << CW) - 1) : 32'd0);
      stall_clr = 1'b1;
      @(posedge clk);
      #1 stall_clr = 1'b0;
      check("stall_clr", 2, 32'(stall_cnt[2*CW +: CW]), 32'd0);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
      step(1'b0, 16'h0000, '0, 4'b0000, 4'b1111);
`endif

      @(negedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stream_fork_buf.md
Name: stream_fork_buf

Overview:
- Registered ready/valid broadcast (eager fork) for a two-field payload. One input stream is fanned out to NUM_OUTPUTS consumers.
- Each consumer is released independently. The input is accepted only once every selected consumer has taken the current item.
- A per-item destination mask selects which outputs receive each item.
- Sits between a stream producer and several parallel consumers. It replaces pure combinational fan-out wiring, where one slow sink stalls all of them.

Parameters:
- NUM_OUTPUTS, 4, number of output channels (1..16)
- DATA_WIDTH, 16, width of unsigned field data
- DATA2_WIDTH, 13, width of signed field data2
- CNT_WIDTH, 16, width of each stall counter (used only with optional feature)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  DATA_WIDTH  payload field, unsigned
- in_data2  input  DATA2_WIDTH  payload field, signed
- in_valid  input  1  input item present
- in_ready  output  1  input item accepted this cycle when in_valid also high
- in_dest  input  NUM_OUTPUTS  destination mask, sampled with the accepted item
- out_data  output  NUM_OUTPUTS*DATA_WIDTH  per-output data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- out_data2  output  NUM_OUTPUTS*DATA2_WIDTH  per-output data2, signed, same packing
- out_valid  output  NUM_OUTPUTS  per-output valid
- out_ready  input  NUM_OUTPUTS  per-output ready

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous, active-low (rst_n).
- State:
  - payload registers pl_data, pl_data2.
  - pending mask pend[NUM_OUTPUTS-1:0]; bit i means output i still owes a transfer.
- Reset values (rst_n low):
  - pend=0, pl_data=0, pl_data2=0.
  - Therefore out_valid=0, out_data=0, out_data2=0.
  - in_ready forced 0 while rst_n low.
- Outputs:
  - out_valid[i]=pend[i].
  - All out_data/out_data2 slices drive pl_data/pl_data2, including slices with pend[i]=0.
  - Signed field is carried bit-exact; no extension.
- Per-output transfer: occurs when out_valid[i] & out_ready[i]. Transferred bits clear at the clock edge: pend <= pend & ~out_ready.
- in_ready = ((pend & ~out_ready) == 0) and rst_n high.
  - Combinational from out_ready, so the last pending transfer and a new accept can share a cycle.
- Accept (in_valid & in_ready):
  - pl_data <= in_data, pl_data2 <= in_data2, pend <= in_dest.
  - Accept overrides the clear term.
- Latency: accept at edge N gives out_valid high from edge N onward; the item is visible one cycle after acceptance.
- Throughput: one item/cycle when all destination outputs hold ready continuously.
- Payload stability: the payload is held stable while any pend bit is set. A transferred output's valid drops, and that output does not see the item twice.
- Boundary cases:
  - in_dest all-zero: item accepted and discarded; pend stays 0; no output sees it.
  - in_valid low with pend=0: state unchanged; in_ready high.
  - Simultaneous transfer on a subset of outputs: only those bits clear; in_ready stays low until the remainder clear.
  - out_ready asserted on an output with pend[i]=0: no effect.
  - Reset mid-operation: in-flight item is dropped; pend cleared immediately (asynchronously); payload zeroed.
  - NUM_OUTPUTS=1: degenerates to a single-stage register slice whose ready passes through.

Optional Feature:
- Macro STREAM_FORK_BUF_STALL_CNT_EN.
- Defined:
  - Adds port stall_clr (input, 1): synchronous clear of all counters, which has priority over increments.
  - Adds port stall_cnt (output, NUM_OUTPUTS*CNT_WIDTH): packed per-output counters.
  - Counter i increments each cycle with out_valid[i] & ~out_ready[i].
  - Counters saturate at all-ones (no wrap) and reset to 0 on rst_n.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then one item:
  - Stimulus: in_data=16'h1234, in_data2=-5, in_dest=4'b1111, in_valid=1 for one cycle, out_ready=4'b1111.
  - Response: accepted; next cycle out_valid=4'b1111 on all channels with 16'h1234 / 13'h1FFB; out_valid=0 the cycle after.
- Staggered consumers:
  - Stimulus: dest=4'b1111, out_ready raised one channel per cycle (bit0..bit3).
  - Response: out_valid goes 1111→1110→1100→1000→0000; in_ready low for 3 cycles, then high in the cycle out_ready[3] rises; payload constant throughout.
- Back-to-back stream:
  - Stimulus: 8 items with values 0..7, all ready held high.
  - Response: one item per cycle on every output, in order, no gaps, no duplicates.
- Mask selection:
  - Stimulus: dest=4'b0101, then dest=4'b0000, then dest=4'b0010.
  - Response: first item only on outputs 0 and 2; second item accepted and never appears; third item only on output 1.
- Reset mid-item:
  - Stimulus: pend=4'b1010 outstanding, rst_n pulsed low asynchronously between edges.
  - Response: out_valid=0 and in_ready=0 immediately; after release in_ready=1 and no stale item reappears.
- With STREAM_FORK_BUF_STALL_CNT_EN, CNT_WIDTH=4:
  - Stimulus: output 2 held not-ready for 20 cycles with an item pending.
  - Response: stall_cnt slice 2 saturates at 15, other slices stay 0; stall_clr for one cycle returns it to 0.
